// File: rtl/lp_fb_arbiter.sv
// ----------------------------------------------------------------------------
// lp_fb_arbiter
//
// Purpose:
//   Arbitrates the single-port, double-banked pixel frame memory of a 64x64
//   LED panel between the scan datapath (front bank, hard real-time reads) and
//   a host pixel writer (back bank, valid/ready). A host bank-swap request is
//   held until the scan reports end of frame, so a frame is never shown torn.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   scan_rd_req       scan wants entry scan_addr this cycle (never stalled)
//   scan_addr         scan read address within the front bank
//   scan_frame_end    1-cycle pulse at the end of the last bit-plane of a frame
//   scan_rdata        read data, passthrough of mem_rdata
//   scan_rvalid       scan_rdata valid, one cycle after a granted read
//   host_wr_valid     host write request
//   host_wr_ready     host write accepted when valid & ready at clk edge
//   host_wr_addr      host write address within the back bank
//   host_wr_data      host write data
//   host_swap_req     1-cycle pulse: back bank complete, request swap
//   swap_pending      swap requested, waiting for scan_frame_end
//   swap_done         1-cycle pulse, the cycle after front_bank changes
//   front_bank        bank currently being scanned
//   host_starved      sticky: host blocked by scan STARVE_MAX cycles in a row
//   mem_addr          {bank, addr} to frame memory
//   mem_we            frame memory write enable
//   mem_wdata         frame memory write data
//   mem_rdata         frame memory read data (1-cycle latency)
// ----------------------------------------------------------------------------
module lp_fb_arbiter #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 24,
    parameter int STARVE_MAX = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scan_rd_req,
    input  logic [ADDR_W-1:0] scan_addr,
    input  logic              scan_frame_end,
    output logic [DATA_W-1:0] scan_rdata,
    output logic              scan_rvalid,
    input  logic              host_wr_valid,
    output logic              host_wr_ready,
    input  logic [ADDR_W-1:0] host_wr_addr,
    input  logic [DATA_W-1:0] host_wr_data,
    input  logic              host_swap_req,
    output logic              swap_pending,
    output logic              swap_done,
    output logic              front_bank,
    output logic              host_starved,
    output logic [ADDR_W:0]   mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_PENDING = 1'b1
    } swap_state_e;

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    swap_state_e state_q;
    logic        front_bank_q;
    logic        toggled_q;     // front bank changed at the previous edge
    logic        swap_done_q;
    logic        scan_rvalid_q;
    logic [7:0]  starve_cnt_q, starve_cnt_d;
    logic        starved_q, starved_d;
    logic        wr_accept;

    assign swap_pending = (state_q == S_PENDING);
    assign front_bank   = front_bank_q;
    assign swap_done    = swap_done_q;
    assign scan_rvalid  = scan_rvalid_q;
    assign host_starved = starved_q;
    assign scan_rdata   = mem_rdata;

    // ------------------------------------------------------------------
    // Memory port grant: scan always wins; host writes only to the back
    // bank and only while no swap is waiting (back bank must stay frozen
    // until it has been displayed).
    // ------------------------------------------------------------------
    always_comb begin
        mem_addr      = '0;
        mem_we        = 1'b0;
        mem_wdata     = '0;
        host_wr_ready = 1'b0;
        if (scan_rd_req) begin
            mem_addr = {front_bank_q, scan_addr};
        end else if (!rst) begin
            if (host_wr_valid && !swap_pending) begin
                mem_addr      = {~front_bank_q, host_wr_addr};
                mem_we        = 1'b1;
                mem_wdata     = host_wr_data;
                host_wr_ready = 1'b1;
            end else begin
                host_wr_ready = !swap_pending;
            end
        end
    end

    assign wr_accept = host_wr_valid && host_wr_ready;

    // ------------------------------------------------------------------
    // Swap FSM. The toggle lands on the scan_frame_end edge, so a read in
    // that same cycle still addresses the old front bank.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            front_bank_q <= 1'b0;
            toggled_q    <= 1'b0;
            swap_done_q  <= 1'b0;
        end else begin
            toggled_q   <= 1'b0;
            swap_done_q <= toggled_q;
            case (state_q)
                S_IDLE: begin
                    if (host_swap_req) begin
                        if (scan_frame_end) begin
                            front_bank_q <= ~front_bank_q;
                            toggled_q    <= 1'b1;
                        end else begin
                            state_q <= S_PENDING;
                        end
                    end
                end
                S_PENDING: begin
                    if (scan_frame_end) begin
                        state_q      <= S_IDLE;
                        front_bank_q <= ~front_bank_q;
                        toggled_q    <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Starvation watch: only blocking by scan counts. Blocking by a
    // pending swap neither counts nor clears the streak.
    // ------------------------------------------------------------------
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!host_wr_valid || wr_accept) begin
            starve_cnt_d = '0;
        end else if (scan_rd_req && (starve_cnt_q != 8'hFF)) begin
            starve_cnt_d = starve_cnt_q + 8'd1;
        end
        starved_d = starved_q || (starve_cnt_d >= STARVE_LIM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q  <= '0;
            starved_q     <= 1'b0;
            scan_rvalid_q <= 1'b0;
        end else begin
            starve_cnt_q  <= starve_cnt_d;
            starved_q     <= starved_d;
            scan_rvalid_q <= scan_rd_req;
        end
    end

endmodule

// File: tb/tb_lp_fb_arbiter.sv
module tb_lp_fb_arbiter;
    localparam int ADDR_W = 11;
    localparam int DATA_W = 24;

    logic              clk = 1'b0;
    logic              rst;
    logic              scan_rd_req;
    logic [ADDR_W-1:0] scan_addr;
    logic              scan_frame_end;
    logic [DATA_W-1:0] scan_rdata;
    logic              scan_rvalid;
    logic              host_wr_valid;
    logic              host_wr_ready;
    logic [ADDR_W-1:0] host_wr_addr;
    logic [DATA_W-1:0] host_wr_data;
    logic              host_swap_req;
    logic              swap_pending;
    logic              swap_done;
    logic              front_bank;
    logic              host_starved;
    logic [ADDR_W:0]   mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lp_fb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(255)) dut (
        .clk(clk), .rst(rst),
        .scan_rd_req(scan_rd_req), .scan_addr(scan_addr),
        .scan_frame_end(scan_frame_end),
        .scan_rdata(scan_rdata), .scan_rvalid(scan_rvalid),
        .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
        .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
        .host_swap_req(host_swap_req), .swap_pending(swap_pending),
        .swap_done(swap_done), .front_bank(front_bank),
        .host_starved(host_starved),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance one edge, then settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; scan_rd_req = 1'b0; scan_addr = '0; scan_frame_end = 1'b0;
        host_wr_valid = 1'b1; host_wr_addr = 11'h055; host_wr_data = 24'h5A5A5A;
        host_swap_req = 1'b0; mem_rdata = '0;
        tick(); tick();
        // reset state, and no write while in reset even with a request
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_ready", 32'(host_wr_ready), 32'd0);
        chk("rst_front", 32'(front_bank), 32'd0);
        chk("rst_pend", 32'(swap_pending), 32'd0);
        chk("rst_done", 32'(swap_done), 32'd0);
        chk("rst_rvalid", 32'(scan_rvalid), 32'd0);
        chk("rst_starved", 32'(host_starved), 32'd0);

        // scan read
        rst = 1'b0; host_wr_valid = 1'b0;
        scan_rd_req = 1'b1; scan_addr = 11'h005; mem_rdata = 24'h123456;
        #1;
        chk("scan_addr", 32'(mem_addr), 32'h005);
        chk("scan_we", 32'(mem_we), 32'd0);
        chk("scan_ready", 32'(host_wr_ready), 32'd0);
        chk("scan_rdata", 32'(scan_rdata), 32'h123456);
        tick();
        scan_rd_req = 1'b0;
        chk("rvalid_1", 32'(scan_rvalid), 32'd1);
        tick();
        chk("rvalid_0", 32'(scan_rvalid), 32'd0);

        // idle host write goes to back bank 1
        host_wr_valid = 1'b1; host_wr_addr = 11'h010; host_wr_data = 24'hABCDEF;
        #1;
        chk("wr_we", 32'(mem_we), 32'd1);
        chk("wr_addr", 32'(mem_addr), 32'h810);
        chk("wr_data", 32'(mem_wdata), 32'hABCDEF);
        chk("wr_ready", 32'(host_wr_ready), 32'd1);
        tick();

        // contention: scan wins, host lands next free cycle
        scan_rd_req = 1'b1; scan_addr = 11'h7FF;
        host_wr_addr = 11'h020; host_wr_data = 24'h111111;
        #1;
        chk("both_addr", 32'(mem_addr), 32'h7FF);
        chk("both_we", 32'(mem_we), 32'd0);
        chk("both_ready", 32'(host_wr_ready), 32'd0);
        tick();
        scan_rd_req = 1'b0;
        #1;
        chk("late_we", 32'(mem_we), 32'd1);
        chk("late_addr", 32'(mem_addr), 32'h820);
        tick();
        host_wr_valid = 1'b0;

        // deferred swap: pending 10 cycles with writes blocked
        host_swap_req = 1'b1;
        tick();
        host_swap_req = 1'b0;
        host_wr_valid = 1'b1; host_wr_addr = 11'h030; host_wr_data = 24'h333333;
        #1;
        chk("pend_set", 32'(swap_pending), 32'd1);
        chk("pend_we", 32'(mem_we), 32'd0);
        chk("pend_ready", 32'(host_wr_ready), 32'd0);
        chk("pend_addr", 32'(mem_addr), 32'h000);
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("pend_hold", 32'(swap_pending), 32'd1);
            chk("pend_front", 32'(front_bank), 32'd0);
        end
        scan_frame_end = 1'b1; scan_rd_req = 1'b1; scan_addr = 11'h001;
        #1;
        chk("fe_old_bank", 32'(mem_addr), 32'h001);
        tick();
        scan_frame_end = 1'b0; scan_rd_req = 1'b0;
        #1;
        chk("swap_front", 32'(front_bank), 32'd1);
        chk("swap_pend_clr", 32'(swap_pending), 32'd0);
        chk("swap_done_early", 32'(swap_done), 32'd0);
        chk("post_we", 32'(mem_we), 32'd1);
        chk("post_addr", 32'(mem_addr), 32'h030);
        tick();
        host_wr_valid = 1'b0;
        chk("swap_done_1", 32'(swap_done), 32'd1);
        tick();
        chk("swap_done_0", 32'(swap_done), 32'd0);

        // immediate swap: request and frame end together
        host_swap_req = 1'b1; scan_frame_end = 1'b1;
        tick();
        host_swap_req = 1'b0; scan_frame_end = 1'b0;
        chk("imm_front", 32'(front_bank), 32'd0);
        chk("imm_pend", 32'(swap_pending), 32'd0);
        tick();
        chk("imm_done", 32'(swap_done), 32'd1);

        // frame end alone does nothing
        scan_frame_end = 1'b1;
        tick();
        scan_frame_end = 1'b0;
        chk("fe_idle_front", 32'(front_bank), 32'd0);

        // go to bank 1, then reset while pending returns to bank 0
        host_swap_req = 1'b1; scan_frame_end = 1'b1;
        tick();
        scan_frame_end = 1'b0;
        chk("imm2_front", 32'(front_bank), 32'd1);
        tick();   // host_swap_req still high: enters PENDING
        host_swap_req = 1'b0;
        chk("pend2", 32'(swap_pending), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_pend_clr", 32'(swap_pending), 32'd0);
        chk("rst_front_0", 32'(front_bank), 32'd0);

        // starvation: a broken streak restarts the count
        host_wr_valid = 1'b1; scan_rd_req = 1'b1;
        repeat (200) tick();
        host_wr_valid = 1'b0;
        tick();
        host_wr_valid = 1'b1;
        repeat (254) tick();
        chk("starve_254", 32'(host_starved), 32'd0);
        tick();
        chk("starve_255", 32'(host_starved), 32'd1);
        scan_rd_req = 1'b0;
        tick();
        host_wr_valid = 1'b0;
        repeat (3) tick();
        chk("starve_sticky", 32'(host_starved), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("starve_rst", 32'(host_starved), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
